// File: rtl/cmul_seq_pkg.sv
// cmul_seq_pkg: shared types and constants for the sequential complex multiplier.
//   state_t         controller states IDLE / ISSUE / LAST / OUT
//   P_RR..P_IR      product index, i.e. the order in which the four real
//                   products are pushed through the shared multiplier
//   LATENCY         cycles from the accept cycle to the first out_valid cycle
//   MULT_W, PROD_W  operand / product width of the mult18x18_1c primitive
package cmul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LAST,
    OUT
  } state_t;

  localparam logic [1:0] P_RR = 2'd0;  // ar*br
  localparam logic [1:0] P_II = 2'd1;  // ai*bi
  localparam logic [1:0] P_RI = 2'd2;  // ar*bi
  localparam logic [1:0] P_IR = 2'd3;  // ai*br

  localparam int LATENCY = 6;
  localparam int MULT_W  = 18;
  localparam int PROD_W  = 2 * MULT_W;

endpackage

// File: rtl/cmul_seq_if.sv
// cmul_seq_if: operand/result handshake bundle of the complex multiplier.
//   in_valid/in_ready    operand pair handshake (a = coefficient, b = sample)
//   a_re, a_im           signed CWIDTH coefficient
//   b_re, b_im           signed IWIDTH sample
//   conj                 only with CMUL_SEQ_CONJ_EN: multiply by conj(b)
//   out_valid/out_ready  result handshake
//   o_re, o_im           signed OWIDTH result
// Modports: master = producer/consumer side, slave = the multiplier.
interface cmul_seq_if #(
  parameter int CWIDTH = 18,
  parameter int IWIDTH = 18,
  parameter int OWIDTH = IWIDTH + CWIDTH + 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [CWIDTH-1:0] a_re;
  logic signed [CWIDTH-1:0] a_im;
  logic signed [IWIDTH-1:0] b_re;
  logic signed [IWIDTH-1:0] b_im;
`ifdef CMUL_SEQ_CONJ_EN
  logic                     conj;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OWIDTH-1:0] o_re;
  logic signed [OWIDTH-1:0] o_im;

  modport master (
`ifdef CMUL_SEQ_CONJ_EN
    output conj,
`endif
    output in_valid, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_valid, o_re, o_im
  );

  modport slave (
`ifdef CMUL_SEQ_CONJ_EN
    input  conj,
`endif
    input  in_valid, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_valid, o_re, o_im
  );
endinterface

// File: rtl/cmul_seq_acc.sv
// cmul_seq_acc: sign-controlled accumulator pair for cmul_seq.
//   clk, rst  clock, synchronous active-low reset (clears both lanes)
//   en        a valid product is present on p this cycle
//   idx       product index of p (P_RR/P_II/P_RI/P_IR)
//   conj      1: build a*conj(b), 0: build a*b
//   p         full-width signed product from the multiplier
//   acc_re    real lane:      load on P_RR, add/sub P_II
//   acc_im    imaginary lane: load on P_RI, add P_IR
// The lanes also serve as the result registers; they only change when a
// product of a new operation lands, so they hold steady during OUT.
module cmul_seq_acc
  import cmul_seq_pkg::*;
#(
  parameter int OWIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               idx,
  input  logic                     conj,
  input  logic signed [PROD_W-1:0] p,
  output logic signed [OWIDTH-1:0] acc_re,
  output logic signed [OWIDTH-1:0] acc_im
);
  // The true product always fits in CWIDTH+IWIDTH <= OWIDTH bits, so a
  // resize (sign-extend or drop redundant sign bits) is exact.
  logic signed [OWIDTH-1:0] pext;
  assign pext = OWIDTH'(p);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam logic [1:0] LOAD_K = (gi == 0) ? P_RR : P_RI;
      localparam logic [1:0] UPD_K  = (gi == 0) ? P_II : P_IR;

      logic                     load_neg;
      logic                     upd_neg;
      logic signed [OWIDTH-1:0] lane_reg;

      // a*b:       re = rr - ii, im =  ri + ir
      // a*conj(b): re = rr + ii, im = -ri + ir
      assign load_neg = (gi == 1) ? conj : 1'b0;
      assign upd_neg  = (gi == 0) ? ~conj : 1'b0;

      always_ff @(posedge clk) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (en) begin
          if (idx == LOAD_K) begin
            lane_reg <= load_neg ? -pext : pext;
          end else if (idx == UPD_K) begin
            lane_reg <= upd_neg ? (lane_reg - pext) : (lane_reg + pext);
          end
        end
      end
    end
  endgenerate

  assign acc_re = g_lane[0].lane_reg;
  assign acc_im = g_lane[1].lane_reg;
endmodule

// File: rtl/mult18x18_1c.sv
// mult18x18_1c: 18x18 signed multiplier with one registered output stage.
//   clk  clock
//   rst  synchronous active-high reset, clears the product register
//   en   clock enable for the product register
//   a, b signed 18-bit operands
//   p    signed 36-bit product, valid the cycle after a/b are driven
module mult18x18_1c (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [17:0] a,
  input  logic signed [17:0] b,
  output logic signed [35:0] p
);
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
    end else if (en) begin
      p <= a * b;
    end
  end
endmodule

// File: rtl/cmul_seq.sv
// cmul_seq: sequential complex multiplier o = a*b on one shared
// mult18x18_1c. Four real products are issued one per cycle and summed
// into the result; one result every 6 cycles, accept-to-out_valid = 6.
//   clk  clock
//   rst  synchronous active-low reset
//   bus  cmul_seq_if.slave: in_valid/in_ready + a/b operands,
//        out_valid/out_ready + o_re/o_im result
// Optional: define CMUL_SEQ_CONJ_EN to add bus.conj (o = a*conj(b)).
module cmul_seq
  import cmul_seq_pkg::*;
#(
  parameter int CWIDTH = 18,
  parameter int IWIDTH = 18,
  parameter int OWIDTH = IWIDTH + CWIDTH + 1
) (
  input logic       clk,
  input logic       rst,
  cmul_seq_if.slave bus
);
  state_t                   state_reg;
  logic [1:0]               idx_reg;
  logic                     out_valid_reg;
  logic                     pv_reg;    // product in the multiplier is ours
  logic [1:0]               pidx_reg;  // index of that product
  logic                     conj_reg;
  logic                     accept;
  logic signed [MULT_W-1:0] opd_in [4];  // ar, ai, br, bi
  logic signed [MULT_W-1:0] opd_reg [4];
  logic signed [MULT_W-1:0] mult_a;
  logic signed [MULT_W-1:0] mult_b;
  logic signed [PROD_W-1:0] mult_p;

  // In OUT the slot frees up on the same edge the result is taken.
  assign bus.in_ready = rst & ((state_reg == IDLE) |
                               ((state_reg == OUT) & bus.out_ready));
  assign accept       = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_reg;

  assign opd_in[0] = MULT_W'(bus.a_re);
  assign opd_in[1] = MULT_W'(bus.a_im);
  assign opd_in[2] = MULT_W'(bus.b_re);
  assign opd_in[3] = MULT_W'(bus.b_im);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) opd_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 4; i++) opd_reg[i] <= opd_in[i];
    end
  end

`ifdef CMUL_SEQ_CONJ_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      conj_reg <= 1'b0;
    end else if (accept) begin
      conj_reg <= bus.conj;
    end
  end
`else
  assign conj_reg = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      pv_reg        <= 1'b0;
      pidx_reg      <= '0;
    end else begin
      // Products leave the multiplier one cycle after issue.
      pv_reg   <= (state_reg == ISSUE);
      pidx_reg <= idx_reg;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= ISSUE;
            idx_reg   <= '0;
          end
        end
        ISSUE: begin
          idx_reg <= idx_reg + 2'd1;
          if (idx_reg == P_IR) state_reg <= LAST;
        end
        LAST: begin
          state_reg     <= OUT;
          out_valid_reg <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            idx_reg       <= '0;
            state_reg     <= accept ? ISSUE : IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mult_a = opd_reg[0];
    mult_b = opd_reg[2];
    case (idx_reg)
      P_II: begin mult_a = opd_reg[1]; mult_b = opd_reg[3]; end
      P_RI: begin mult_a = opd_reg[0]; mult_b = opd_reg[3]; end
      P_IR: begin mult_a = opd_reg[1]; mult_b = opd_reg[2]; end
      default: ;
    endcase
  end

  mult18x18_1c u_mult (
    .clk (clk),
    .rst (~rst),
    .en  (1'b1),
    .a   (mult_a),
    .b   (mult_b),
    .p   (mult_p)
  );

  cmul_seq_acc #(
    .OWIDTH (OWIDTH)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .en     (pv_reg),
    .idx    (pidx_reg),
    .conj   (conj_reg),
    .p      (mult_p),
    .acc_re (bus.o_re),
    .acc_im (bus.o_im)
  );
endmodule

// File: tb/tb_cmul_seq.sv
// tb_cmul_seq: self-checking bench for cmul_seq. Expected results come from
// plain complex arithmetic on longint; timing expectations are the fixed
// 6-cycle accept-to-out_valid latency. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_cmul_seq;
  localparam int CW = 18;
  localparam int IW = 18;
  localparam int OW = IW + CW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cmul_seq_if #(.CWIDTH(CW), .IWIDTH(IW), .OWIDTH(OW)) bus ();

  cmul_seq #(.CWIDTH(CW), .IWIDTH(IW), .OWIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void model(input longint ar, input longint ai,
                                input longint br, input longint bi,
                                input bit cj,
                                output longint er, output longint ei);
    if (cj) begin
      er = ar * br + ai * bi;
      ei = ai * br - ar * bi;
    end else begin
      er = ar * br - ai * bi;
      ei = ar * bi + ai * br;
    end
  endfunction

  function automatic longint rnd_s(input int w);
    longint span;
    span = longint'(1) << w;
    return longint'($urandom_range(32'(span - 1), 0)) - (span >>> 1);
  endfunction

  task automatic set_ops(input longint ar, input longint ai,
                         input longint br, input longint bi, input bit cj);
    bus.a_re = CW'(ar);
    bus.a_im = CW'(ai);
    bus.b_re = IW'(br);
    bus.b_im = IW'(bi);
`ifdef CMUL_SEQ_CONJ_EN
    bus.conj = cj;
`else
    if (cj) $display("note: conj requested but feature not built");
`endif
  endtask

  // One complete transaction; reports the result, the latency in cycles
  // from the accept edge, and whether every bounded wait completed.
  task automatic run_one(input longint ar, input longint ai,
                         input longint br, input longint bi, input bit cj,
                         output longint gr, output longint gim,
                         output int lat, output bit ok);
    int n;
    ok = 1'b0; lat = 0; gr = 0; gim = 0;
    @(negedge clk);
    set_ops(ar, ai, br, bi, cj);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin bus.in_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin @(negedge clk); lat++; end
    if (bus.out_valid) begin
      ok  = 1'b1;
      gr  = bus.o_re;
      gim = bus.o_im;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    $display("txn a=(%0d,%0d) b=(%0d,%0d) conj=%0d -> o=(%0d,%0d) lat=%0d",
             ar, ai, br, bi, cj, gr, gim, lat);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    set_ops(0, 0, 0, 0, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.o_re !== '0 || bus.o_im !== '0) begin bad++; $display("FAIL reset_o got=(%0d,%0d) want=(0,0)", bus.o_re, bus.o_im); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", bus.in_ready); end
    $display("txn reset released");
  endtask

  task automatic test_basic();
    @(negedge clk);
    set_ops(3, 4, 5, 6, 1'b0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);             // accept edge T
    @(negedge clk);             // cycle T+1
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready c=%0d got=%b want=0", c, bus.in_ready); end
      total++; if (bus.out_valid !== (c == 6)) begin bad++; $display("FAIL basic_out_valid c=%0d got=%b want=%b", c, bus.out_valid, c == 6); end
    end
    total++; if (bus.o_re !== OW'(-9) || bus.o_im !== OW'(38)) begin bad++; $display("FAIL basic_value got=(%0d,%0d) want=(-9,38)", bus.o_re, bus.o_im); end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_idle got=(ov=%b,ir=%b) want=(0,1)", bus.out_valid, bus.in_ready); end
    $display("txn basic (3+4j)*(5+6j) -> (%0d,%0d)", bus.o_re, bus.o_im);
  endtask

  task automatic test_full_range();
    longint gr, gim, er, ei; int lat; bit ok;
    run_one(-131072, -131072, -131072, -131072, 1'b0, gr, gim, lat, ok);
    model(-131072, -131072, -131072, -131072, 1'b0, er, ei);
    total++; if (!ok) begin bad++; $display("FAIL full_timeout got=no_result want=result"); end
    total++; if (gr !== 0 || gim !== 64'sd34359738368) begin bad++; $display("FAIL full_value got=(%0d,%0d) want=(0,34359738368)", gr, gim); end
    total++; if (gr !== er || gim !== ei) begin bad++; $display("FAIL full_model got=(%0d,%0d) want=(%0d,%0d)", gr, gim, er, ei); end
  endtask

  task automatic test_random();
    longint ar, ai, br, bi, gr, gim, er, ei; int lat; bit ok, cj;
    for (int t = 0; t < 12; t++) begin
      ar = rnd_s(CW); ai = rnd_s(CW); br = rnd_s(IW); bi = rnd_s(IW);
`ifdef CMUL_SEQ_CONJ_EN
      cj = 1'($urandom_range(1, 0));
`else
      cj = 1'b0;
`endif
      run_one(ar, ai, br, bi, cj, gr, gim, lat, ok);
      model(ar, ai, br, bi, cj, er, ei);
      total++; if (!ok || lat != 6) begin bad++; $display("FAIL rand_latency t=%0d got=%0d want=6", t, lat); end
      total++; if (gr !== er || gim !== ei) begin bad++; $display("FAIL rand_value t=%0d got=(%0d,%0d) want=(%0d,%0d)", t, gr, gim, er, ei); end
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    longint ar, ai, br, bi, er, ei; int n; bit late_valid;
    ar = rnd_s(CW); ai = rnd_s(CW); br = rnd_s(IW); bi = rnd_s(IW);
    model(ar, ai, br, bi, 1'b0, er, ei);
    @(negedge clk);
    set_ops(ar, ai, br, bi, 1'b0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin @(negedge clk); n++; end
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b want=1", bus.out_valid); end
    set_ops(1, 2, 3, 4, 1'b0);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.o_re !== OW'(er) || bus.o_im !== OW'(ei)) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=(ov=%b,ir=%b,%0d,%0d) want=(1,0,%0d,%0d)",
                 c, bus.out_valid, bus.in_ready, bus.o_re, bus.o_im, er, ei);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=(ov=%b,ir=%b) want=(0,1)", bus.out_valid, bus.in_ready); end
    late_valid = 1'b0;
    repeat (8) begin @(negedge clk); if (bus.out_valid) late_valid = 1'b1; end
    total++; if (late_valid !== 1'b0) begin bad++; $display("FAIL bp_no_second got=%b want=0", late_valid); end
    $display("txn backpressure -> (%0d,%0d)", er, ei);
  endtask

  task automatic test_back_to_back();
    longint p_ar[4], p_ai[4], p_br[4], p_bi[4];
    longint er, ei;
    int sent, got, cyc, last_cyc;
    bit fire, extra;
    for (int i = 0; i < 4; i++) begin
      p_ar[i] = rnd_s(CW); p_ai[i] = rnd_s(CW);
      p_br[i] = rnd_s(IW); p_bi[i] = rnd_s(IW);
    end
    sent = 0; got = 0; cyc = 0; last_cyc = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_ops(p_ar[0], p_ai[0], p_br[0], p_bi[0], 1'b0);
    bus.in_valid = 1'b1;
    while (got < 4 && cyc < 100) begin
      if (bus.out_valid) begin
        model(p_ar[got], p_ai[got], p_br[got], p_bi[got], 1'b0, er, ei);
        total++; if (bus.o_re !== OW'(er) || bus.o_im !== OW'(ei)) begin bad++; $display("FAIL b2b_value n=%0d got=(%0d,%0d) want=(%0d,%0d)", got, bus.o_re, bus.o_im, er, ei); end
        total++; if (cyc - last_cyc != 6) begin bad++; $display("FAIL b2b_spacing n=%0d got=%0d want=6", got, cyc - last_cyc); end
        $display("txn b2b n=%0d -> (%0d,%0d) at cycle %0d", got, bus.o_re, bus.o_im, cyc);
        last_cyc = cyc;
        got++;
      end
      fire = bus.in_valid & bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      if (fire) begin
        if (sent == 0) last_cyc = cyc;  // accept cycle of the first pair
        sent++;
        if (sent < 4) set_ops(p_ar[sent], p_ai[sent], p_br[sent], p_bi[sent], 1'b0);
        else bus.in_valid = 1'b0;
      end
      cyc++;
    end
    total++; if (got != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", got); end
    extra = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.out_valid) extra = 1'b1; end
    total++; if (extra !== 1'b0) begin bad++; $display("FAIL b2b_duplicate got=%b want=0", extra); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    longint gr, gim; int lat; bit ok, seen;
    @(negedge clk);
    set_ops(7, -3, 2, 9, 1'b0);
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);             // accept edge T
    @(negedge clk);             // T+1, idx 0
    bus.in_valid = 1'b0;
    @(negedge clk);             // T+2, idx 1
    @(negedge clk);             // T+3, idx 2
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    total++; if (bus.o_re !== '0 || bus.o_im !== '0) begin bad++; $display("FAIL midrst_clear got=(%0d,%0d) want=(0,0)", bus.o_re, bus.o_im); end
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", seen); end
    run_one(1, 1, 1, -1, 1'b0, gr, gim, lat, ok);
    total++; if (!ok || lat != 6) begin bad++; $display("FAIL midrst_latency got=%0d want=6", lat); end
    total++; if (gr !== 2 || gim !== 0) begin bad++; $display("FAIL midrst_value got=(%0d,%0d) want=(2,0)", gr, gim); end
  endtask

`ifdef CMUL_SEQ_CONJ_EN
  task automatic test_conj();
    longint gr, gim; int lat; bit ok;
    run_one(3, 4, 5, 6, 1'b1, gr, gim, lat, ok);
    total++; if (!ok || gr !== 39 || gim !== 2) begin bad++; $display("FAIL conj1_value got=(%0d,%0d) want=(39,2)", gr, gim); end
    run_one(3, 4, 5, 6, 1'b0, gr, gim, lat, ok);
    total++; if (!ok || gr !== -9 || gim !== 38) begin bad++; $display("FAIL conj0_value got=(%0d,%0d) want=(-9,38)", gr, gim); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full_range();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
`ifdef CMUL_SEQ_CONJ_EN
    test_conj();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
